// File: rtl/fir_fdmt_pkg.sv
// Shared definitions for the FIR sign-magnitude datapath converters.
// Used by unsigned_to_signed_pipe and its forward signed-to-magnitude counterpart.
package fir_fdmt_pkg;

    localparam int DEFAULT_BIT_WIDTH = 17;

    // Sign-magnitude sample as carried between the converters at default width.
    typedef struct packed {
        logic                         sign;
        logic [DEFAULT_BIT_WIDTH-2:0] mag;
        logic                         last;
    } sm_sample_t;

    localparam int SM_SAMPLE_W = $bits(sm_sample_t);

endpackage

// File: rtl/unsigned_to_signed_pipe_stage_reg.sv
// pipe_stage_reg: one valid/ready register slice. The slice accepts whenever it is
// empty or its content leaves this cycle; the payload register loads only on accept.
module pipe_stage_reg #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         v;
    logic [W-1:0] d;

    assign in_ready  = !v || out_ready;
    assign out_valid = v;
    assign out_data  = d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            if (in_ready) begin
                v <= in_valid;
            end
            if (in_valid && in_ready) begin
                d <= in_data;
            end
        end
    end

endmodule

// File: rtl/unsigned_to_signed_pipe.sv
// Two-stage sign-magnitude to two's-complement converter with valid/ready flow control.
// Optional macro U2S_NEGZERO_CNT_EN adds a saturating count of accepted negative zeros.
//
// Handshake: a transfer happens on a rising edge where valid && ready; valid and
// payload are held by the producer until that edge, ready may depend on the far side.
module unsigned_to_signed_pipe
    import fir_fdmt_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-2:0] in_mag,
    input  logic                 in_sign,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_last
`ifdef U2S_NEGZERO_CNT_EN
    ,
    output logic [15:0]          negzero_cnt
`endif
);

    localparam int PW = BIT_WIDTH + 1;

    logic          s1_v;
    logic          s2_in_ready;
    logic [PW-1:0] s1_d;
    logic [PW-1:0] s1_q;
    logic [PW-1:0] s2_d;
    logic [PW-1:0] s2_q;

    logic                 s1_sign;
    logic [BIT_WIDTH-2:0] s1_mag;
    logic                 s1_last;
    logic [BIT_WIDTH-1:0] mag_ext;
    logic [BIT_WIDTH-1:0] conv;

    assign s1_d = {in_sign, in_mag, in_last};

    pipe_stage_reg #(.W(PW)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d),
        .out_valid (s1_v),
        .out_ready (s2_in_ready),
        .out_data  (s1_q)
    );

    assign s1_sign = s1_q[PW-1];
    assign s1_mag  = s1_q[PW-2:1];
    assign s1_last = s1_q[0];
    assign mag_ext = {1'b0, s1_mag};

    // Negative zero maps to plain zero, so the most negative code never appears.
    assign conv = (s1_sign && (s1_mag != '0)) ? (~mag_ext + 1'b1) : mag_ext;
    assign s2_d = {conv, s1_last};

    pipe_stage_reg #(.W(PW)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_v),
        .in_ready  (s2_in_ready),
        .in_data   (s2_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_data = s2_q[PW-1:1];
    assign out_last = s2_q[0];

`ifdef U2S_NEGZERO_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            negzero_cnt <= 16'h0000;
        end else if (in_valid && in_ready && in_sign && (in_mag == '0)
                     && (negzero_cnt != 16'hFFFF)) begin
            negzero_cnt <= negzero_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/unsigned_to_signed_pipe.md
Name: unsigned_to_signed_pipe

Overview:
Streaming converter from sign-magnitude samples (unsigned magnitude plus sign flag) back to two's-complement signed samples. It is the inverse direction of the FIR datapath's signed-to-magnitude front end, and sits after the magnitude-domain multiply stages to rebuild signed products for accumulation. It is a 2-stage registered pipeline with valid/ready backpressure and frame-boundary passthrough.

Parameters:
BIT_WIDTH, 17, width of the signed output (2^n + 1); the magnitude is BIT_WIDTH-1 bits.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  input sample valid
in_ready  output  1  block can accept an input this cycle
in_mag  input  BIT_WIDTH-1  unsigned magnitude
in_sign  input  1  1 = negative
in_last  input  1  last sample of frame, passed through unchanged
out_valid  output  1  output sample valid
out_ready  input  1  downstream accepts the output
out_data  output  BIT_WIDTH  signed two's-complement result
out_last  output  1  delayed copy of in_last

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Transfers: input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
- Stage 1 (S1) registers mag, sign and last, with valid bit s1_v.
- Stage 2 (S2) drives the outputs: out_data = (sign && mag != 0) ? -{1'b0, mag} : {1'b0, mag}, computed on BIT_WIDTH bits. out_valid = s2_v.
- Advance rules:
  - s2_adv = !s2_v || out_ready.
  - s1_adv = s1_v && s2_adv.
  - in_ready = !s1_v || s2_adv. This is a combinational path from out_ready; it is accepted at 2 stages.
- Latency: 2 cycles from input transfer to out_valid with no stalls. Throughput is 1 sample per cycle.
- Stall: while out_valid && !out_ready, out_data and out_last hold stable. With both stages full, in_ready = 0.
- Ordering: samples are never dropped, duplicated or reordered.
- Simultaneous events: an S2 drain and an S1 refill in the same cycle keep full throughput.
- Arithmetic range:
  - Output range is -(2^(BIT_WIDTH-1)-1) to +(2^(BIT_WIDTH-1)-1).
  - The most negative code, 1 followed by zeros, is never produced.
  - No overflow is possible.
- Negative zero: sign=1 with mag=0 produces out_data = 0.
- Reset values: s1_v = 0, s2_v = 0, out_valid = 0, out_data = 0, out_last = 0, and in_ready = 1 during and after reset.
- Reset mid-operation discards all in-flight samples. The first output after reset is the first sample accepted after reset.
- Data registers update only when their stage advances, which gives no toggling on idle.

Optional Feature:
Macro U2S_NEGZERO_CNT_EN.
- Defined: adds output port negzero_cnt [15:0]. It increments on each input transfer with in_sign=1 and in_mag=0, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Shared package fir_fdmt_pkg:
  - constant DEFAULT_BIT_WIDTH = 17.
  - typedef for the sign-magnitude sample struct {sign, mag, last}, shared with the forward converter.
- One natural sub-module: pipe_stage_reg, a generic valid/ready register slice instantiated twice with payload width BIT_WIDTH+1. The negation sits between S1 and S2 in the top level.

Test Plan:
1. BIT_WIDTH=17, out_ready=1; send mag=16'h0005 sign=1, then mag=16'h0005 sign=0 -> out_data 17'h1FFFB then 17'h00005, each exactly 2 cycles after acceptance.
2. Extremes: mag=16'hFFFF sign=1 -> 17'h10001; mag=16'hFFFF sign=0 -> 17'h0FFFF; mag=0 sign=1 -> 17'h00000. With U2S_NEGZERO_CNT_EN, negzero_cnt=1.
3. Backpressure: hold out_ready=0, offer 3 samples (1, 2, 3 positive) -> 2 accepted, in_ready=0, out_data stable at 1. Release out_ready -> outputs 1, 2, 3 in order, 3rd accepted on the release cycle.
4. Streaming 64 random samples with random out_ready (50%) and in_last on every 8th -> the scoreboard matches every value and out_last position, with no gaps when out_ready=1 continuously.
5. Reset mid-stream: 2 samples in flight, assert rst_n=0 for 1 cycle -> out_valid=0 and out_data=0 next edge, in_ready=1; the next accepted sample emerges first.
6. Exhaustive BIT_WIDTH=5: all 16 magnitudes × 2 signs -> out_data equals the reference negation, and 5'b10000 is never seen.
